pc_unit: RTL and testbench

Parametrised program-counter generator at the head of the Fetch stage. It replaces the single-register PC+4/write-back mux with a multi-source generator:
- sequential increment, branch/jump redirect and trap redirect, in priority order;
- a stall input;
- a valid/ready request handshake toward instruction memory;
- a one-cycle flush pulse for wrong-path kill;
- misaligned-target detection.

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_redirect_hold.sv | 63 ++++++
 rtl/pc_unit.sv | 124 ++++++++++++
 tb/tb_pc_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_unit_pkg;

  localparam int unsigned DefaultXlen      = 32;
  localparam int unsigned DefaultInc       = 4;
  localparam int unsigned DefaultAlignBits = 2;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold,
    StFault
  } pc_state_e;

  // SrcSeq doubles as "no redirect target present".
  typedef enum logic [1:0] {
    SrcSeq,
    SrcBr,
    SrcTrap
  } pc_src_e;

endpackage

// File: rtl/pc_redirect_hold.sv
// Trap/redirect priority select merged with a single pending target that survives
// until the in-flight fetch request is accepted.
module pc_redirect_hold
  import pc_unit_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            capture,
  input  logic            drop,
  output pc_src_e         tgt_src,
  output logic [XLEN-1:0] tgt_pc
);

  pc_src_e         pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  pc_src_e         new_src;
  logic [XLEN-1:0] new_pc;

  always_comb begin
    new_src = SrcSeq;
    new_pc  = redirect_pc;
    if (trap_valid) begin
      new_src = SrcTrap;
      new_pc  = trap_pc;
    end else if (redirect_valid) begin
      new_src = SrcBr;
    end

    // A latched trap may only be displaced by another trap.
    tgt_src = pend_src_q;
    tgt_pc  = pend_pc_q;
    if (new_src == SrcTrap || (new_src == SrcBr && pend_src_q != SrcTrap)) begin
      tgt_src = new_src;
      tgt_pc  = new_pc;
    end

    pend_src_d = pend_src_q;
    pend_pc_d  = pend_pc_q;
    if (drop) begin
      pend_src_d = SrcSeq;
    end else if (capture) begin
      pend_src_d = tgt_src;
      pend_pc_d  = tgt_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_src_q <= SrcSeq;
      pend_pc_q  <= '0;
    end else begin
      pend_src_q <= pend_src_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC generator: sequential/redirect/trap sources, valid/ready request
// handshake, wrong-path flush pulse and misaligned-target fault.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     INC        = DefaultInc,
  parameter int unsigned     ALIGN_BITS = DefaultAlignBits
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_pc,
  output logic [XLEN-1:0] pc_4,
  output logic            flush,
  output logic            misalign
);

  localparam logic [XLEN-1:0] IncVal    = XLEN'(INC);
  localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic            out_q, out_d;  // request presented last cycle and not yet accepted
  logic            capture, drop, apply;
  logic            fire, unacc;
  pc_src_e         tgt_src;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_valid;

  pc_redirect_hold #(
    .XLEN(XLEN)
  ) u_redirect_hold (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .capture       (capture),
    .drop          (drop),
    .tgt_src       (tgt_src),
    .tgt_pc        (tgt_pc)
  );

  assign tgt_valid = (tgt_src != SrcSeq);
  // An issued request stays valid through stall until it fires.
  assign req_valid = (state_q == StHold) || ((state_q == StRun) && (!stall || out_q));
  assign fire      = req_valid & req_ready;
  assign unacc     = req_valid & ~req_ready;
  assign req_pc    = pc_q;
  assign pc_4      = pc_q + IncVal;
  assign flush     = flush_q;
  assign misalign  = misalign_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    out_d   = unacc;
    capture = 1'b0;
    drop    = 1'b0;
    apply   = 1'b0;

    unique case (state_q)
      StBoot: begin
        if (tgt_valid) apply = 1'b1;
        else           state_d = StRun;
      end
      StRun: begin
        if (tgt_valid && unacc) begin
          capture = 1'b1;
          state_d = StHold;
        end else if (tgt_valid) begin
          apply = 1'b1;
        end else if (fire) begin
          pc_d = pc_q + IncVal;
        end
      end
      StHold: begin
        if (fire) apply = 1'b1;
        else      capture = 1'b1;
      end
      StFault: begin
        if (tgt_valid) apply = 1'b1;
      end
      default: state_d = StBoot;
    endcase

    if (apply) begin
      pc_d    = tgt_pc;
      flush_d = 1'b1;
      drop    = 1'b1;
      state_d = ((tgt_pc & AlignMask) != '0) ? StFault : StRun;
    end
    misalign_d = (state_d == StFault);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic, all
// compared against a behavioural fetch-PC model.
module tb_pc_unit;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INC        = 4;
  localparam int unsigned ALIGN_BITS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pc_4;
  logic            flush;
  logic            misalign;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: current PC, boot/fault flags, whether a request is outstanding,
  // and at most one deferred target.
  logic [XLEN-1:0] m_pc;
  bit              m_boot, m_fault, m_held, m_flush, m_valid;
  bit              m_pend, m_pend_trap;
  logic [XLEN-1:0] m_pend_pc;

  pc_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0000_0000),
    .INC       (INC),
    .ALIGN_BITS(ALIGN_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pc        (req_pc),
    .pc_4          (pc_4),
    .flush         (flush),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_fault = 1'b0;
    m_held  = 1'b0;
    m_flush = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check_eq("rst_req_pc", {32'd0, req_pc}, 64'h0);
    check_eq("rst_pc_4", {32'd0, pc_4}, 64'h4);
    check_eq("rst_flush", {63'd0, flush}, 64'd0);
    check_eq("rst_misalign", {63'd0, misalign}, 64'd0);
  endtask

  task automatic model_advance(input bit rv, input logic [XLEN-1:0] rpc, input bit tv,
                               input logic [XLEN-1:0] tpc, input bit rdy);
    bit              have, t_trap;
    logic [XLEN-1:0] t;
    have   = 1'b0;
    t_trap = 1'b0;
    t      = '0;
    if (tv) begin
      have = 1'b1; t = tpc; t_trap = 1'b1;
    end else if (rv) begin
      have = 1'b1; t = rpc;
    end
    // Deferred target survives unless displaced (traps beat everything, redirects beat redirects).
    if (m_pend && !(have && (t_trap || !m_pend_trap))) begin
      have = 1'b1; t = m_pend_pc; t_trap = m_pend_trap;
    end
    if (have && m_valid && !rdy) begin
      m_pend = 1'b1; m_pend_pc = t; m_pend_trap = t_trap;
      m_held = 1'b1; m_flush = 1'b0;
    end else if (have) begin
      m_pc    = t;
      m_fault = (t % (1 << ALIGN_BITS)) != 0;
      m_boot  = 1'b0;
      m_pend  = 1'b0;
      m_held  = 1'b0;
      m_flush = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (m_valid && rdy) m_pc = m_pc + INC;
      m_boot = 1'b0;
      m_held = m_valid && !rdy;
    end
  endtask

  task automatic step(input bit st, input bit rv, input logic [XLEN-1:0] rpc, input bit tv,
                      input logic [XLEN-1:0] tpc, input bit rdy);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_pc = tpc; req_ready = rdy;
    #1;
    m_valid = !m_boot && !m_fault && (m_held || !st);
    check_eq("req_valid", {63'd0, req_valid}, {63'd0, m_valid});
    check_eq("req_pc", {32'd0, req_pc}, {32'd0, m_pc});
    check_eq("pc_4", {32'd0, pc_4}, {32'd0, m_pc + 32'(INC)});
    check_eq("flush", {63'd0, flush}, {63'd0, m_flush});
    check_eq("misalign", {63'd0, misalign}, {63'd0, m_fault});
    @(posedge clk);
    model_advance(rv, rpc, tv, tpc, rdy);
  endtask

  task automatic idle(input bit st, input bit rdy);
    step(st, 1'b0, '0, 1'b0, '0, rdy);
  endtask

  // Called right after a posedge: reset pulse lands strictly between edges.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0; req_ready = 1'b0;
    #7 check_reset_outputs();
    model_reset();
    #2 rst = 1'b0;

    // Boot then sequential 0x0, 0x4, 0x8.
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Unaccepted request at 0x8 held through toggling stall, then fires.
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Simultaneous redirect and trap: trap wins, single-cycle flush.
    step(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Redirects deferred while 0x10 is unaccepted; the later one replaces the earlier.
    step(1'b0, 1'b1, 32'h10, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0, '0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Misaligned redirect faults; stall ignored; trap recovers.
    step(1'b0, 1'b1, 32'h102, 1'b0, '0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 32'h80, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Reset mid-hold discards the deferred target.
    idle(1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h500, 1'b0, '0, 1'b0);
    async_reset();
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [XLEN-1:0] rpc, tpc;
      rpc = $urandom;
      tpc = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) tpc[1:0] = 2'b00;
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rpc,
             $urandom_range(0, 11) == 0, tpc, $urandom_range(0, 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
